glyph_anim_mux: RTL and testbench

Multi-digit character animator and display scanner for the hero game's 7-segment panel. It generalises the per-character glyph ROMs to NUM_DIGITS independent channels. Each channel holds a selected character and plays a timed jump (up) or duck (down) pose that returns to neutral on its own. A time-multiplexed scan drives one shared segment bus plus per-digit enables.

---
 rtl/glyph_pkg.sv | 42 ++++
 rtl/glyph_anim_mux_if.sv | 21 ++
 rtl/glyph_chan.sv | 75 +++++++
 rtl/glyph_anim_mux.sv | 84 ++++++++
 tb/tb_glyph_anim_mux.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/glyph_pkg.sv
// Shared glyph codes, character codes and channel states for the 7-segment animator.
package glyph_pkg;

    // Segment patterns, abcdefg with bit 6 = a.
    localparam logic [6:0] GLYPH_U     = 7'b0111110;
    localparam logic [6:0] GLYPH_I     = 7'b0000110;
    localparam logic [6:0] GLYPH_P     = 7'b1100111;
    localparam logic [6:0] GLYPH_F     = 7'b1000111;
    localparam logic [6:0] GLYPH_E     = 7'b1001111;
    localparam logic [6:0] GLYPH_UP    = 7'b1000000;
    localparam logic [6:0] GLYPH_DOWN  = 7'b0001000;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    // Codes 5..7 are not enumerated; they all render blank.
    typedef enum logic [2:0] {
        CharU = 3'd0,
        CharI = 3'd1,
        CharP = 3'd2,
        CharF = 3'd3,
        CharE = 3'd4
    } char_e;

    typedef enum logic [1:0] {
        NEUTRAL = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2
    } chan_state_e;

    function automatic logic [6:0] char_glyph(input logic [2:0] code);
        logic [6:0] g;
        case (code)
            CharU:   g = GLYPH_U;
            CharI:   g = GLYPH_I;
            CharP:   g = GLYPH_P;
            CharF:   g = GLYPH_F;
            CharE:   g = GLYPH_E;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/glyph_anim_mux_if.sv
// Panel-side bundle: character selects and pose requests in, scanned display and busy out.
interface glyph_anim_mux_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [3*NUM_DIGITS-1:0] char_sel;
    logic [NUM_DIGITS-1:0]   jump;
    logic [NUM_DIGITS-1:0]   duck;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [NUM_DIGITS-1:0]   busy;

    modport master (
        output char_sel, jump, duck,
        input  seg, an, busy
    );

    modport slave (
        input  char_sel, jump, duck,
        output seg, an, busy
    );
endinterface

// File: rtl/glyph_chan.sv
// One digit channel: pose FSM with tick-based hold counter and combinational glyph lookup.
module glyph_chan
    import glyph_pkg::*;
#(
    parameter int unsigned HOLD_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       jump,
    input  logic       duck,
    input  logic [2:0] char_sel,
    output logic       busy,
    output logic [6:0] glyph
);
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HoldLoad = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HoldOne  = HW'(1);

    chan_state_e     state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;

    // State and hold counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NEUTRAL;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: requests only accepted in NEUTRAL (jump beats duck); the expiring tick wins.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            NEUTRAL: begin
                if (jump) begin
                    state_d = UP;
                    hold_d  = HoldLoad;
                end else if (duck) begin
                    state_d = DOWN;
                    hold_d  = HoldLoad;
                end
            end
            UP, DOWN: begin
                if (tick) begin
                    if (hold_q == HoldOne) begin
                        state_d = NEUTRAL;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - HoldOne;
                    end
                end
            end
            default: begin
                state_d = NEUTRAL;
                hold_d  = '0;
            end
        endcase
    end

    // Glyph for the current pose; neutral follows char_sel live.
    always_comb begin
        busy = (state_q != NEUTRAL);
        unique case (state_q)
            UP:      glyph = GLYPH_UP;
            DOWN:    glyph = GLYPH_DOWN;
            default: glyph = char_glyph(char_sel);
        endcase
    end

endmodule

// File: rtl/glyph_anim_mux.sv
// Multi-digit glyph animator: time base, digit channels, scanner and registered panel outputs.
module glyph_anim_mux
    import glyph_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned HOLD_TICKS = 250,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            rst,
    glyph_anim_mux_if.slave bus
);
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] ScanMax = SW'(NUM_DIGITS - 1);
    localparam logic          Inv     = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SegOff = {7{Inv}};
    localparam logic [NUM_DIGITS-1:0] AnOff  = {NUM_DIGITS{Inv}};

    logic [TW-1:0]         tick_q, tick_d;
    logic                  tick;
    logic [SW-1:0]         scan_q, scan_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [NUM_DIGITS-1:0] busy_vec;
    logic [6:0]            glyph [NUM_DIGITS];

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_chan
        glyph_chan #(
            .HOLD_TICKS (HOLD_TICKS)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .jump     (bus.jump[d]),
            .duck     (bus.duck[d]),
            .char_sel (bus.char_sel[3*d +: 3]),
            .busy     (busy_vec[d]),
            .glyph    (glyph[d])
        );
    end

    // Time base and scan index advance.
    always_comb begin
        tick   = (tick_q == TickMax);
        tick_d = tick ? '0 : tick_q + TW'(1);
        scan_d = scan_q;
        if (tick) begin
            scan_d = (scan_q == ScanMax) ? '0 : scan_q + SW'(1);
        end
    end

    // Output mux with polarity applied before the output register.
    always_comb begin
        seg_d = glyph[scan_q];
        an_d  = NUM_DIGITS'(1) << scan_q;
        if (Inv) begin
            seg_d = ~seg_d;
            an_d  = ~an_d;
        end
    end

    // Counters and output registers; outputs idle at the inactive level in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
            scan_q <= '0;
            seg_q  <= SegOff;
            an_q   <= AnOff;
        end else begin
            tick_q <= tick_d;
            scan_q <= scan_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.busy = busy_vec;

endmodule

// File: tb/tb_glyph_anim_mux.sv
// Bench for glyph_anim_mux: active-high and active-low instances share stimulus and a model.
module tb_glyph_anim_mux;
    localparam int unsigned N = 4;
    localparam int unsigned T = 4;
    localparam int unsigned H = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    glyph_anim_mux_if #(.NUM_DIGITS(N)) bus0 ();
    glyph_anim_mux_if #(.NUM_DIGITS(N)) bus1 ();

    glyph_anim_mux #(
        .NUM_DIGITS (N),
        .TICK_DIV   (T),
        .HOLD_TICKS (H),
        .ACTIVE_LOW (0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    glyph_anim_mux #(
        .NUM_DIGITS (N),
        .TICK_DIV   (T),
        .HOLD_TICKS (H),
        .ACTIVE_LOW (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int tests = 0;
    int fails = 0;

    logic [3*N-1:0] cs;
    logic [N-1:0]   jmp;
    logic [N-1:0]   dck;

    // Model: edges since reset release, and per digit the pose kind and the edge it ends on.
    int unsigned e;
    bit          posed  [N];
    bit          is_up  [N];
    int unsigned end_e  [N];
    logic [6:0]  ref_glyph [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] model_seg(input int unsigned d);
        logic [2:0] code;
        if (posed[d]) return is_up[d] ? 7'b1000000 : 7'b0001000;
        code = cs[3*d +: 3];
        return ref_glyph[code];
    endfunction

    task automatic drive(input logic [N-1:0] j, input logic [N-1:0] dk, input logic [3*N-1:0] c);
        jmp = j;
        dck = dk;
        cs  = c;
        bus0.jump = j;  bus0.duck = dk;  bus0.char_sel = c;
        bus1.jump = j;  bus1.duck = dk;  bus1.char_sel = c;
    endtask

    task automatic model_reset();
        e = 0;
        for (int d = 0; d < N; d++) begin
            posed[d] = 1'b0;
            is_up[d] = 1'b0;
            end_e[d] = 0;
        end
    endtask

    task automatic chk_reset();
        chk("rst_seg0", {25'd0, bus0.seg}, 32'h00);
        chk("rst_an0", {28'd0, bus0.an}, 32'h0);
        chk("rst_busy0", {28'd0, bus0.busy}, 32'h0);
        chk("rst_seg1", {25'd0, bus1.seg}, 32'h7f);
        chk("rst_an1", {28'd0, bus1.an}, 32'hf);
        chk("rst_busy1", {28'd0, bus1.busy}, 32'h0);
    endtask

    // One clock: predict from pre-edge state and inputs, then compare after the edge.
    task automatic cycle();
        logic [6:0]  xs;
        logic [N-1:0] xa;
        logic [N-1:0] xb;
        int unsigned sc;
        sc = (e / T) % N;
        xa = '0;
        xa[sc] = 1'b1;
        xs = model_seg(sc);
        for (int d = 0; d < N; d++) begin
            if (posed[d]) begin
                if (e == end_e[d]) posed[d] = 1'b0;
            end else if (jmp[d] || dck[d]) begin
                posed[d] = 1'b1;
                is_up[d] = jmp[d];
                // Last of H ticks counted strictly after edge e.
                end_e[d] = ((e + 1) / T + H - 1) * T + T - 1;
            end
            xb[d] = posed[d];
        end
        e++;
        @(posedge clk);
        #1;
        chk("seg", {25'd0, bus0.seg}, {25'd0, xs});
        chk("an", {28'd0, bus0.an}, {28'd0, xa});
        chk("busy", {28'd0, bus0.busy}, {28'd0, xb});
        chk("seg_al", {25'd0, bus1.seg}, {25'd0, ~xs});
        chk("an_al", {28'd0, bus1.an}, {28'd0, ~xa});
        chk("busy_al", {28'd0, bus1.busy}, {28'd0, xb});
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [N-1:0]   rj;
        logic [N-1:0]   rd;
        logic [3*N-1:0] rc;

        ref_glyph[0] = 7'b0111110;
        ref_glyph[1] = 7'b0000110;
        ref_glyph[2] = 7'b1100111;
        ref_glyph[3] = 7'b1000111;
        ref_glyph[4] = 7'b1001111;
        ref_glyph[5] = 7'b0000000;
        ref_glyph[6] = 7'b0000000;
        ref_glyph[7] = 7'b0000000;

        // char_sel = {E, F, P, U}
        drive('0, '0, {3'd4, 3'd3, 3'd2, 3'd0});
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;

        // Plain scan of the four characters.
        run(34);

        // Single-cycle jump on digit 1.
        drive(4'b0010, '0, cs);
        cycle();
        drive('0, '0, cs);
        run(20);

        // Jump and duck together on digit 2, then a late duck that must be ignored.
        drive(4'b0100, 4'b0100, cs);
        cycle();
        drive('0, '0, cs);
        run(8);
        drive('0, 4'b0100, cs);
        cycle();
        drive('0, '0, cs);
        run(12);

        // Continuous duck on digit 0.
        drive('0, 4'b0001, cs);
        run(40);
        drive('0, '0, cs);
        run(16);

        // Blank code on digit 3, then a duck there.
        drive('0, '0, {3'd6, cs[8:0]});
        run(8);
        drive('0, 4'b1000, cs);
        cycle();
        drive('0, '0, cs);
        run(20);

        // Randomised requests and character changes, including mid-pose char_sel changes.
        for (int i = 0; i < 600; i++) begin
            rj = '0;
            rd = '0;
            for (int d = 0; d < N; d++) begin
                rj[d] = ($urandom_range(0, 11) == 0);
                rd[d] = ($urandom_range(0, 11) == 0);
            end
            rc = cs;
            if ($urandom_range(0, 15) == 0) rc = 12'($urandom);
            drive(rj, rd, rc);
            cycle();
        end

        // Reset in the middle of poses.
        drive('1, '0, cs);
        cycle();
        drive('0, '0, cs);
        cycle();
        rst = 1'b1;
        #1;
        chk_reset();
        @(posedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
